load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the CPU datapath and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake. Translates byte addresses to word addresses and performs sub-word stores as read-modify-write sequences. Returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

## Interface

Parameters:
- ADDR_W, 15, width of the memory word address; the word index is byte address [ADDR_W+1:2]
- DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer occurs on the edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid
- mem_addr  out  ADDR_W  word address to data memory, registered
- mem_we  out  1  write strobe; memory commits mem_wdata at the rising edge while high
- mem_wdata  out  32  full word to write, registered
- mem_rdata  in  32  combinational read of word at mem_addr

## Operation

- Little-endian lanes:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (0 selects [15:0], 1 selects [31:16]).
- Request capture: on accept, latch we, size, signed, addr, wdata. Load mem_addr <= addr[ADDR_W+1:2].
- Fault check at accept. Any of the following is a fault:
  - size == 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:ADDR_W+2] != 0

  A faulting request goes straight to RESP with resp_fault = 1. mem_we is never asserted and mem_addr is not updated.
- FSM states and transitions:
  - IDLE: req_ready = 1. On accept:
    - fault -> RESP
    - load -> READ
    - word store -> WRITE, with mem_wdata <= req_wdata
    - sub-word store -> READ
  - READ: mem_addr stable, mem_we = 0. mem_rdata is sampled at the edge.
    - Load: extract lane, extend per signed, register into resp_rdata, -> RESP.
    - Sub-word store: register merged word into mem_wdata (unselected lanes from mem_rdata, selected lane from wdata low bits), -> WRITE.
  - WRITE: mem_we = 1 for exactly this cycle, -> RESP.
  - RESP: resp_valid = 1 for exactly this cycle, with resp_rdata and resp_fault. -> IDLE.
- Requests presented while not in IDLE are held off (req_ready = 0). They are neither dropped nor double-accepted.
- Word load ignores req_signed.

## Timing

- Cycle 0 is the accept edge. resp_valid is high in the following cycle:
  - load: cycle 2
  - word store: cycle 2 (mem_we in cycle 1)
  - sub-word store: cycle 3 (READ cycle 1, mem_we cycle 2)
  - fault: cycle 1
- Back-to-back: the next accept is possible at the earliest on the edge ending the RESP cycle's successor. IDLE lasts at least one cycle between requests.
- mem_we is a registered decode of state == WRITE. It is never high in any other state, and never high for two consecutive cycles.
- Reset values (asynchronous):
  - state IDLE, so req_ready = 1 once out of reset
  - resp_valid 0, resp_rdata 0, resp_fault 0
  - mem_we 0, mem_addr 0, mem_wdata 0
- Reset mid-operation: the transaction is abandoned, mem_we drops immediately, and no response is issued. A write already committed at an earlier edge stands. A read-modify-write interrupted in READ leaves memory unchanged.
- Outputs mem_addr and mem_wdata hold their last value in IDLE and RESP.

## Test plan

Memory model initialised with ram[i] = i, write on clock edge when mem_we is high.

- LW addr 0x0000_0014 accepted at cycle 0 -> mem_addr = 5 in cycle 1. resp_valid and resp_rdata = 0x0000_0005 in cycle 2, resp_fault = 0.
- SW 0xDEADBEEF at 0x08, then:
  - LB signed 0x09 -> 0xFFFFFFBE
  - LBU 0x09 -> 0x000000BE
  - LH signed 0x0A -> 0xFFFFDEAD
  - LHU 0x08 -> 0x0000BEEF
- SB wdata 0x00000077 at 0x0D (word 3 holds 0x3) -> mem_we single pulse in cycle 2 with mem_wdata = 0x00007703. resp_valid in cycle 3 with resp_rdata = 0.
- Faults, each giving resp_fault = 1 in cycle 1 with mem_we never high and memory unchanged:
  - LH at 0x03
  - SW at 0x06
  - LW at 0x0002_0000
  - size 11
- req_valid held high continuously with three LW requests -> exactly three accepts and three responses in order. req_ready = 0 in every non-IDLE cycle.
- rst_n pulsed low during the WRITE cycle of an SB -> mem_we falls asynchronously and no resp_valid follows. req_ready = 1 after release, and the next LW returns correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, byte addresses mapped onto a
// word-organised memory, sub-word stores done as read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;

  logic              accept;
  logic              misaligned;
  logic              addr_oob;
  logic              req_fault;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Any byte-address bit above the implemented word index is out of range.
  assign addr_oob  = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign req_fault = misaligned | addr_oob;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_data = mem_rdata;
    case (size_q)
      SZ_BYTE: load_data = signed_q ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      SZ_HALF: load_data = signed_q ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Unselected lanes keep the word just read; the selected lane takes store data.
  always_comb begin
    merged_word = mem_rdata;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0:    merged_word[7:0]   = wdata_q[7:0];
        2'd1:    merged_word[15:8]  = wdata_q[7:0];
        2'd2:    merged_word[23:16] = wdata_q[7:0];
        default: merged_word[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged_word[31:16] = wdata_q;
    end else begin
      merged_word[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d         = req_we;
          size_d       = req_size;
          signed_d     = req_signed;
          lane_d       = req_addr[1:0];
          wdata_d      = req_wdata[15:0];
          resp_rdata_d = '0;
          resp_fault_d = req_fault;
          if (req_fault) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (req_we && (req_size == SZ_WORD)) begin
              mem_wdata_d = req_wdata;
              state_d     = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          mem_wdata_d = merged_word;
          state_d     = S_WRITE;
        end else begin
          resp_rdata_d = load_data;
          state_d      = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are clean registered outputs.
    mem_we_d     = (state_d == S_WRITE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

  a_we_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we_q |=> !mem_we_q);
  a_we_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we_q |-> (state_q == S_WRITE));
  a_resp_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_q |=> !resp_valid_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand-written
// back-to-back and mid-operation reset sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(15), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = i;
  end
  assign mem_rdata = ram[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    int          rc;
    logic [31:0] rd;
    logic        flt;
    int          wc;
    logic [31:0] ewd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // Observed results of one transaction.
  bit          r_timeout;
  int          r_resp_cyc, r_resp_cnt, r_we_cyc, r_we_cnt;
  logic [31:0] r_rdata, r_wdata, r_maddr1;
  logic        r_fault;
  bit          r_ready_bad;

  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    r_timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        r_timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    r_resp_cyc = 0; r_resp_cnt = 0; r_we_cyc = 0; r_we_cnt = 0;
    r_rdata = '0; r_wdata = '0; r_fault = 1'b0; r_maddr1 = '0; r_ready_bad = 1'b0;
    if (r_timeout) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        r_maddr1 = {17'd0, mem_addr};
      end
      if (mem_we) begin
        r_we_cnt++;
        if (r_we_cyc == 0) begin
          r_we_cyc = c;
          r_wdata = mem_wdata;
        end
      end
      if (resp_valid) begin
        r_resp_cnt++;
        if (r_resp_cyc == 0) begin
          r_resp_cyc = c;
          r_rdata = resp_rdata;
          r_fault = resp_fault;
        end
      end
      if ((r_resp_cyc == 0 || r_resp_cyc == c) && req_ready) r_ready_bad = 1'b1;
      if (r_resp_cyc != 0 && c == r_resp_cyc + 1 && !req_ready) r_ready_bad = 1'b1;
    end
  endtask

  logic [31:0] exp_maddr;
  logic [31:0] b2b_addr [3];
  int          acc_k [3];
  int          rsp_k [3];
  logic [31:0] rsp_d [3];
  logic [31:0] exp_final [8];

  initial begin
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,         2, 32'h0000_0005, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEADBEEF,  2, 32'h0,         1'b0, 1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0,         2, 32'hFFFF_FFBE, 1'b0, 0, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         2, 32'h0000_00BE, 1'b0, 0, 32'h0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         2, 32'hFFFF_DEAD, 1'b0, 0, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0,         2, 32'h0000_BEEF, 1'b0, 0, 32'h0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_0077, 3, 32'h0,         1'b0, 2, 32'h0000_7703};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,         2, 32'h0000_7703, 1'b0, 0, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0,         1, 32'h0,         1'b1, 0, 32'h0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1234_5678, 1, 32'h0,         1'b1, 0, 32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0002_0000, 32'h0,         1, 32'h0,         1'b1, 0, 32'h0};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         1, 32'h0,         1'b1, 0, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         2, 32'h0000_0001, 1'b0, 0, 32'h0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hABCD_1234, 3, 32'h0,         1'b0, 2, 32'h1234_0004};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         2, 32'h0000_0012, 1'b0, 0, 32'h0};
    vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_00FF, 3, 32'h0,         1'b0, 2, 32'h1234_00FF};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         2, 32'hFFFF_FFFF, 1'b0, 0, 32'h0};
    vecs[17] = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,         2, 32'h1234_00FF, 1'b0, 0, 32'h0};

    exp_final[0] = 32'h0;         exp_final[1] = 32'h1;
    exp_final[2] = 32'hDEADBEEF;  exp_final[3] = 32'h0000_7703;
    exp_final[4] = 32'h1234_00FF; exp_final[5] = 32'h5;
    exp_final[6] = 32'h6;         exp_final[7] = 32'h7;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",      {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   {17'd0, mem_addr},   32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    rst_n = 1'b1;
    exp_maddr = 32'd0;

    for (int v = 0; v < NV; v++) begin
      run_txn(vecs[v].we, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd);
      check($sformatf("v%0d_accept", v), {31'd0, r_timeout}, 32'd0);
      if (!vecs[v].flt) exp_maddr = {17'd0, vecs[v].addr[16:2]};
      check($sformatf("v%0d_resp_cycle", v), r_resp_cyc, vecs[v].rc);
      check($sformatf("v%0d_resp_count", v), r_resp_cnt, 32'd1);
      check($sformatf("v%0d_rdata", v), r_rdata, vecs[v].rd);
      check($sformatf("v%0d_fault", v), {31'd0, r_fault}, {31'd0, vecs[v].flt});
      check($sformatf("v%0d_we_cycle", v), r_we_cyc, vecs[v].wc);
      check($sformatf("v%0d_we_count", v), r_we_cnt, (vecs[v].wc != 0) ? 32'd1 : 32'd0);
      if (vecs[v].wc != 0) check($sformatf("v%0d_wdata", v), r_wdata, vecs[v].ewd);
      check($sformatf("v%0d_mem_addr", v), r_maddr1, exp_maddr);
      check($sformatf("v%0d_ready_pattern", v), {31'd0, r_ready_bad}, 32'd0);
      $display("txn %0d: we=%0b size=%0b addr=0x%08h -> resp_cyc=%0d rdata=0x%08h fault=%0b we_cyc=%0d",
               v, vecs[v].we, vecs[v].sz, vecs[v].addr, r_resp_cyc, r_rdata, r_fault, r_we_cyc);
    end

    for (int i = 0; i < 8; i++) check($sformatf("mem_word%0d", i), ram[i], exp_final[i]);

    // Back-to-back: req_valid held high across three word loads
    begin
      int  nacc, nrsp, last;
      bit  upd, rdy_bad;
      nacc = 0; nrsp = 0; last = -10; upd = 1'b0; rdy_bad = 1'b0;
      b2b_addr[0] = 32'h18; b2b_addr[1] = 32'h1C; b2b_addr[2] = 32'h20;
      for (int i = 0; i < 3; i++) begin acc_k[i] = 0; rsp_k[i] = 0; rsp_d[i] = '0; end
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = b2b_addr[0];
      for (int k = 0; k < 20; k++) begin
        if (k > 0) @(negedge clk);
        if (upd) begin
          upd = 1'b0;
          if (nacc < 3) req_addr = b2b_addr[nacc];
          else req_valid = 1'b0;
        end
        if (resp_valid) begin
          if (nrsp < 3) begin rsp_k[nrsp] = k; rsp_d[nrsp] = resp_rdata; end
          nrsp++;
        end
        if ((k - last == 1 || k - last == 2) && req_ready) rdy_bad = 1'b1;
        if (req_valid && req_ready && nacc < 3) begin
          acc_k[nacc] = k; nacc++; last = k; upd = 1'b1;
        end
      end
      check("b2b_accepts",   nacc, 32'd3);
      check("b2b_responses", nrsp, 32'd3);
      check("b2b_ready_low", {31'd0, rdy_bad}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_rdata%0d", i), rsp_d[i], 32'd6 + i);
        check($sformatf("b2b_latency%0d", i), rsp_k[i] - acc_k[i], 32'd2);
        if (i > 0) check($sformatf("b2b_spacing%0d", i), acc_k[i] - acc_k[i-1], 32'd3);
        $display("b2b %0d: accept@%0d resp@%0d rdata=0x%08h", i, acc_k[i], rsp_k[i], rsp_d[i]);
      end
    end

    // Reset asserted during the WRITE cycle of a byte store
    begin
      int nresp;
      nresp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h19; req_wdata = 32'h55;
      check("rmw_rst_ready_before", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rmw_rst_we_read", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      check("rmw_rst_we_write", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmw_rst_we_async", {31'd0, mem_we}, 32'd0);
      check("rmw_rst_ready_async", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (resp_valid) nresp++;
        @(negedge clk);
      end
      check("rmw_rst_no_resp", nresp, 32'd0);
      check("rmw_rst_mem_word6", ram[6], 32'd6);
      check("rmw_rst_mem_addr", {17'd0, mem_addr}, 32'd0);
      $display("reset-in-write: responses=%0d word6=0x%08h", nresp, ram[6]);
      run_txn(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
      check("post_rst_accept", {31'd0, r_timeout}, 32'd0);
      check("post_rst_rdata", r_rdata, 32'd6);
      check("post_rst_resp_cycle", r_resp_cyc, 32'd2);
      check("post_rst_fault", {31'd0, r_fault}, 32'd0);
      $display("post-reset LW 0x18: rdata=0x%08h resp_cyc=%0d", r_rdata, r_resp_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
